// File: rtl/alu_param.sv
// Parametrised multi-cycle ALU: one opcode per start/done transaction, 2*WIDTH result,
// iterative shift-add multiplier, fixed-latency sp ops and a small load/store register file.
module alu_param #(
    parameter int WIDTH  = 8,
    parameter int NREGS  = 8,
    parameter int SP_LAT = 3,
    localparam int AW    = $clog2(NREGS),
    localparam int RW    = 2 * WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [3:0]    op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [AW-1:0] addr,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [RW-1:0] result
);

    // state    | meaning
    // S_IDLE   | waiting for start with a non-nop opcode
    // S_ACCEPT | operands captured, counters/multiplier being primed
    // S_MUL    | one multiplier bit per cycle, LSB first
    // S_SPW    | fixed-latency wait for sp0/sp1/sp2
    // S_DONE   | result computed; done/result/error registered on exit

    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + SP_LAT);

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_XOR   = 4'h3;
    localparam logic [3:0] OP_MUL   = 4'h4;
    localparam logic [3:0] OP_SP0   = 4'h5;
    localparam logic [3:0] OP_SP1   = 4'h6;
    localparam logic [3:0] OP_SP2   = 4'h7;
    localparam logic [3:0] OP_LOAD  = 4'h8;
    localparam logic [3:0] OP_STORE = 4'h9;
    localparam logic [3:0] OP_SHL   = 4'hA;
    localparam logic [3:0] OP_SHR   = 4'hB;
    localparam logic [3:0] OP_NOP1  = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_MUL,
        S_SPW,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [AW-1:0]    addr_q;
    logic [CW-1:0]    cnt;
    logic [RW-1:0]    acc, mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] regs [NREGS];

    logic [RW-1:0] res_calc;
    logic [RW-1:0] a_x, b_x;
    logic          is_rsvd;
    logic          is_sp;

    assign is_sp   = (op_q == OP_SP0) || (op_q == OP_SP1) || (op_q == OP_SP2);
    assign is_rsvd = (op_q == 4'hC) || (op_q == 4'hD) || (op_q == 4'hE);
    assign busy    = (state == S_MUL) || (state == S_SPW) || (state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start && (op != OP_NOP) && (op != OP_NOP1)) begin
                    state_next = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                if (op_q == OP_MUL) begin
                    state_next = S_MUL;
                end else if (is_sp) begin
                    state_next = S_SPW;
                end else begin
                    state_next = S_DONE;
                end
            end
            S_MUL, S_SPW: begin
                if (cnt == '0) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        a_x      = RW'(a_q);
        b_x      = RW'(b_q);
        res_calc = '0;
        case (op_q)
            OP_ADD:  res_calc = a_x + b_x;
            OP_AND:  res_calc = a_x & b_x;
            OP_XOR:  res_calc = a_x ^ b_x;
            OP_MUL:  res_calc = acc;
            OP_SP0:  res_calc = a_x + (b_x << 1);
            OP_SP1:  res_calc = a_x << 1;
            OP_SP2:  res_calc = a_x + (a_x << 1);
            OP_LOAD: res_calc = RW'(regs[addr_q]);
            OP_SHL:  res_calc = a_x << b_q[SW-1:0];
            OP_SHR:  res_calc = a_x >> b_q[SW-1:0];
            default: res_calc = '0;
        endcase
    end

    // Results and register writes commit only on the DONE exit edge, so a reset
    // mid-operation leaves no trace.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            addr_q <= '0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            done   <= 1'b0;
            error  <= 1'b0;
            result <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            done <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (state_next == S_ACCEPT) begin
                        op_q   <= op;
                        a_q    <= a;
                        b_q    <= b;
                        addr_q <= addr;
                    end
                end
                S_ACCEPT: begin
                    cnt    <= (op_q == OP_MUL) ? CW'(WIDTH - 1) : CW'(SP_LAT - 2);
                    acc    <= '0;
                    mcand  <= RW'(a_q);
                    mplier <= b_q;
                end
                S_MUL: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - 1'b1;
                end
                S_SPW: begin
                    cnt <= cnt - 1'b1;
                end
                S_DONE: begin
                    result <= res_calc;
                    error  <= is_rsvd;
                    if (op_q == OP_STORE) begin
                        regs[addr_q] <= a_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_param.sv
// Self-checking bench for alu_param: directed scenarios plus randomized opcodes
// compared against a plain-arithmetic reference model with its own register file.
module tb_alu_param;

    localparam int W  = 8;
    localparam int NR = 8;
    localparam int SP = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [W-1:0] a, b;
    logic [2:0]  addr;
    logic        busy, done, error;
    logic [2*W-1:0] result;

    int vectors    = 0;
    int miscompares = 0;

    logic [W-1:0]   mregs [NR];
    logic [2*W-1:0] last_res;
    logic           last_err;

    alu_param #(.WIDTH(W), .NREGS(NR), .SP_LAT(SP)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .addr   (addr),
        .busy   (busy),
        .done   (done),
        .error  (error),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] model_res(input logic [3:0] o, input logic [W-1:0] av,
                                                 input logic [W-1:0] bv, input logic [2:0] ad);
        longint unsigned x, y, r;
        x = av;
        y = bv;
        case (o)
            4'h1:    r = x + y;
            4'h2:    r = x & y;
            4'h3:    r = x ^ y;
            4'h4:    r = x * y;
            4'h5:    r = x + 2 * y;
            4'h6:    r = 2 * x;
            4'h7:    r = 3 * x;
            4'h8:    r = mregs[ad];
            4'hA:    r = x << (y % W);
            4'hB:    r = x >> (y % W);
            default: r = 0;
        endcase
        return (2*W)'(r);
    endfunction

    function automatic int model_lat(input logic [3:0] o);
        if (o == 4'h4) return W + 2;
        if (o >= 4'h5 && o <= 4'h7) return SP + 1;
        return 2;
    endfunction

    task automatic scramble();
        a    = W'($urandom);
        b    = W'($urandom);
        op   = 4'($urandom);
        addr = 3'($urandom);
    endtask

    task automatic run_op(input logic [3:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [2:0] ad);
        logic [2*W-1:0] exp_res;
        logic           exp_err;
        int lat, n, bcnt;
        bit seen;
        exp_res = model_res(o, av, bv, ad);
        exp_err = (o >= 4'hC && o <= 4'hE);
        lat     = model_lat(o);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        addr  = ad;
        @(posedge clk);
        #1 scramble();
        n = 0;
        bcnt = 0;
        seen = 0;
        while (!seen && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (busy) bcnt++;
            if (done) seen = 1;
            else scramble();
        end
        start = 1'b0;
        check($sformatf("lat_op%0h", o), 64'(n), 64'(lat));
        check($sformatf("busy_op%0h", o), 64'(bcnt), 64'(lat - 1));
        check($sformatf("res_op%0h", o), 64'(result), 64'(exp_res));
        check($sformatf("err_op%0h", o), 64'(error), 64'(exp_err));
        @(posedge clk);
        #1;
        check("done_width", 64'(done), 64'(0));
        check("busy_after", 64'(busy), 64'(0));
        if (o == 4'h9) mregs[ad] = av;
        last_res = exp_res;
        last_err = exp_err;
    endtask

    task automatic nop_hold(input logic [3:0] o);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("nop_done", 64'(done), 64'(0));
            check("nop_busy", 64'(busy), 64'(0));
            check("nop_res", 64'(result), 64'(last_res));
            check("nop_err", 64'(error), 64'(last_err));
        end
        start = 1'b0;
    endtask

    initial begin
        int dcnt;
        reset = 1'b1;
        start = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        addr = '0;
        for (int i = 0; i < NR; i++) mregs[i] = '0;
        last_res = '0;
        last_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_err", 64'(error), 64'(0));
        check("rst_res", 64'(result), 64'(0));
        @(negedge clk) reset = 1'b0;

        run_op(4'h1, 8'hFF, 8'h01, 3'd0);
        run_op(4'h4, 8'hFF, 8'hFF, 3'd0);
        run_op(4'h9, 8'h5A, 8'h00, 3'd3);
        run_op(4'h8, 8'h00, 8'h00, 3'd3);
        run_op(4'h8, 8'h00, 8'h00, 3'd4);
        run_op(4'hD, 8'h11, 8'h22, 3'd3);
        run_op(4'h8, 8'h00, 8'h00, 3'd3);
        run_op(4'h1, 8'h01, 8'h02, 3'd0);
        run_op(4'h5, 8'hFF, 8'hFF, 3'd0);
        run_op(4'h6, 8'hFF, 8'h00, 3'd0);
        run_op(4'h7, 8'hFF, 8'h00, 3'd0);
        run_op(4'hA, 8'h81, 8'h03, 3'd0);
        run_op(4'hB, 8'h81, 8'h03, 3'd0);
        run_op(4'hA, 8'hFF, 8'hFF, 3'd0);
        nop_hold(4'h0);
        nop_hold(4'hF);

        for (int i = 0; i < 150; i++) begin
            run_op(4'($urandom_range(1, 14)), W'($urandom), W'($urandom),
                   3'($urandom_range(0, NR - 1)));
        end

        // Abort a multiply with reset; nothing may complete or persist.
        run_op(4'h9, 8'h77, 8'h00, 3'd5);
        @(negedge clk);
        start = 1'b1;
        op = 4'h4;
        a = 8'hFF;
        b = 8'hFF;
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_res", 64'(result), 64'(0));
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < NR; i++) mregs[i] = '0;
        last_res = '0;
        last_err = 1'b0;
        dcnt = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
        end
        check("abort_no_done", 64'(dcnt), 64'(0));
        run_op(4'h8, 8'h00, 8'h00, 3'd5);
        run_op(4'h8, 8'h00, 8'h00, 3'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_param.md
# alu_param

Parametrised successor to the 8-bit ALU593 arithmetic unit. It executes one opcode per start/done transaction on WIDTH-bit operands and produces a 2×WIDTH result. It adds an iterative shift-add multiplier with WIDTH-cycle latency, a variable shift amount, an NREGS-entry register file for load/store, a busy indication, and an error flag for reserved opcodes. It sits in the datapath wherever ALU593 sat.

## Interface
- WIDTH, 8: operand width. Must be ≥4 and a power of two.
- NREGS, 8: register-file depth. Must be a power of two, ≥2. AW = $clog2(NREGS).
- SP_LAT, 3: latency in cycles of the sp0/sp1/sp2 ops. Must be ≥2.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while idle.
- op  in  4  opcode, captured with start.
- a  in  WIDTH  operand A, captured with start.
- b  in  WIDTH  operand B, captured with start.
- addr  in  AW  register-file index for load/store, captured with start.
- busy  out  1  high from the cycle after acceptance until done is asserted.
- done  out  1  one-cycle completion pulse.
- error  out  1  valid with done; 1 only for reserved opcodes.
- result  out  2×WIDTH  valid with done; holds until the next done.

## Operation
- Opcodes (op, result, zero-extended to 2×WIDTH):
  - 0x0 nop: no operation.
  - 0x1 add: A+B.
  - 0x2 and: A&B.
  - 0x3 xor: A^B.
  - 0x4 mul: A×B.
  - 0x5 sp0: A+2B.
  - 0x6 sp1: 2A.
  - 0x7 sp2: 3A.
  - 0x8 load: result = regs[addr].
  - 0x9 store: regs[addr] ← A; result = 0.
  - 0xA shl: A << b[$clog2(WIDTH)-1:0]. No truncation to WIDTH.
  - 0xB shr: A >> b[$clog2(WIDTH)-1:0].
  - 0xC–0xE reserved: error=1, result=0, no register write.
  - 0xF nop1: no operation.
- Arithmetic is unsigned and computed at full 2×WIDTH. No overflow is possible.
- FSM states:
  - IDLE → ACCEPT when start=1 and op is not nop/nop1.
  - ACCEPT → DONE for single-cycle ops.
  - ACCEPT → MUL for mul.
  - ACCEPT → SPW for sp0/sp1/sp2.
  - MUL → DONE after WIDTH iterations. One multiplier bit per cycle, LSB first, shift-add into a 2×WIDTH accumulator.
  - SPW → DONE after its counter expires.
  - DONE → IDLE unconditionally.
- Operands, op and addr are registered at acceptance. Input changes after acceptance have no effect.
- start=1 with nop/nop1 in IDLE: ignored. FSM stays IDLE, no done, busy=0, and result/error are unchanged.
- start while busy or in DONE: ignored, not queued. The requester must hold start until done (this matches the existing tester), and a held start re-launches only from IDLE, i.e. the cycle after done.
- error is updated on every done. A legal op clears it.
- Reset value of every output: busy=0, done=0, error=0, result=0.
- Reset returns the FSM to IDLE and clears all register-file entries to 0. Reset wins over every other event, including mid-operation; the aborted op produces no done and no register write.

## Timing
- Acceptance edge E0: start=1 in IDLE with a non-nop op.
- Latency L, counted from E0 to the edge at which done goes high:
  - add/and/xor/load/store/shl/shr/reserved: L=2.
  - mul: L=WIDTH+2.
  - sp0/sp1/sp2: L=SP_LAT+1.
- busy goes high at E0+1 and falls at E0+L, coincident with done rising.
- done is high for exactly one cycle, then low.
- result and error change only at the edge where done rises.
- The earliest next acceptance is edge E0+L+1. Back-to-back transactions therefore occupy L+1 cycles each.
- A store is visible to a load accepted at or after E0+L+1.

## Test plan
- Reset, then add A=0xFF, B=0x01 (WIDTH=8) → done 2 edges after acceptance, result=0x0100, error=0, busy high for 1 cycle.
- mul A=0xFF, B=0xFF → done at E0+10, result=0xFE01, busy high 9 cycles. Toggling a/b/op mid-operation does not change the result.
- store A=0x5A addr=3, then load addr=3 → result=0x005A. Load addr=4 → 0x0000. Store returns result=0.
- op=0xD → done at E0+2, error=1, result=0. Register file unchanged. A following add 0x01+0x02 gives error=0, result=0x0003.
- Reset asserted at E0+4 of a mul → next cycle busy=0, done=0, result=0. No done ever pulses for that op. A load from a previously stored address returns 0.
- Other ops:
  - sp0 A=0xFF, B=0xFF → 0x02FD at E0+4.
  - shl A=0x81, B=0x03 → 0x0408.
  - shr A=0x81, B=0x03 → 0x0010.
  - nop with start held 3 cycles → no done, busy=0.
